// File: rtl/alu_exec_seq_if.sv
// Request/response bundle for alu_exec_seq: decode-side request with
// valid/ready, and writeback-side result with valid/ready.
// The master drives requests and consumes results; the slave is the execute unit.
interface alu_exec_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      alu_ctrl;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output in_valid, funct3, funct7, alu_op, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_ctrl, result, illegal
    );

    modport slave (
        input  in_valid, funct3, funct7, alu_op, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_ctrl, result, illegal
    );
endinterface

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: handshaked integer execute unit.
// Decodes funct3/funct7/alu_op into a registered control code and computes
// the result. Base RV32I/RV64I ops complete in one cycle. When the macro
// M_EXT_EN is defined, M-extension multiply/divide runs on an iterative
// one-bit-per-cycle sequencer (IDLE -> MUL/DIV -> DONE); otherwise the
// sequencer is removed and funct7=0000001 decodes as illegal.
module alu_exec_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic          clk,
    input  logic          nreset,
    alu_exec_seq_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    // One-cycle base operation selected by alu_ctrl[3:0].
    function automatic logic [XLEN-1:0] alu_base(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [SH_W-1:0] sh
    );
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: return {{(XLEN-1){1'b0}}, (a < b)};
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return $signed(a) >>> sh;
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return '0;
        endcase
    endfunction

    // Output registers
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      ctrl_q;
    logic            illegal_q;

    // Decode results
    logic [4:0]      dec_ctrl;
    logic            dec_illegal;
    logic [XLEN-1:0] base_res;
    logic            accept;

    // Decode the request into a control code and legality flag.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        case (bus.alu_op)
            2'b00: dec_ctrl = 5'b00000;
            2'b01: dec_ctrl = 5'b01000;
            2'b10: begin
                if (bus.funct7 == 7'b0000000) begin
                    dec_ctrl = {2'b00, bus.funct3};
                end else if (bus.funct7 == 7'b0100000) begin
                    // Only ADD->SUB and SRL->SRA have an alternate form.
                    dec_ctrl    = {2'b01, bus.funct3};
                    dec_illegal = !((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101));
                end else if (bus.funct7 == 7'b0000001) begin
`ifdef M_EXT_EN
                    dec_ctrl = {2'b10, bus.funct3};
`else
                    dec_ctrl    = 5'b10000;
                    dec_illegal = 1'b1;
`endif
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_ctrl = {1'b0, (bus.funct3 == 3'b101) ? bus.funct7[5] : 1'b0, bus.funct3};
        endcase
        base_res = dec_illegal ? '0
                 : alu_base(dec_ctrl[3:0], bus.rs1_data, bus.rs2_data, bus.rs2_data[SH_W-1:0]);
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.illegal   = illegal_q;
    assign accept        = bus.in_valid & bus.in_ready;

`ifdef M_EXT_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] acc_hi;     // product high word / partial remainder
    logic [XLEN-1:0] acc_lo;     // multiplier then product low word / quotient
    logic [XLEN-1:0] opd;        // multiplicand or divisor magnitude
    logic            neg_a;
    logic            neg_b;
    logic            div_zero;
    logic [2:0]      m_f3;

    logic            sgn_a, sgn_b, ent_neg_a, ent_neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_diff;
    logic            div_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo, rem;
    logic [XLEN-1:0] m_result;

    // Operand conditioning, one iteration step of each sequencer, and sign fix-up.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            3'b010:                 sgn_a = 1'b1;
            default: ;
        endcase
        ent_neg_a = sgn_a & bus.rs1_data[XLEN-1];
        ent_neg_b = sgn_b & bus.rs2_data[XLEN-1];
        mag_a     = ent_neg_a ? -bus.rs1_data : bus.rs1_data;
        mag_b     = ent_neg_b ? -bus.rs2_data : bus.rs2_data;

        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opd : '0)};

        rem_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = rem_shift >= {1'b0, opd};
        // When div_ge holds the difference is below the divisor and fits XLEN bits.
        rem_diff  = rem_shift[XLEN-1:0] - opd;

        prod_fix  = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo       = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
        rem       = neg_a ? -acc_hi : acc_hi;   // remainder sign follows the dividend

        case (m_f3)
            3'b000:                 m_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         m_result = div_zero ? '1 : quo;
            default:                m_result = rem;
        endcase
    end

    assign bus.in_ready = nreset & (state == S_IDLE) & (!out_valid_q | bus.out_ready);

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            // NOTE: datapath registers are reset too; they are few and this keeps X out of simulation.
            acc_hi      <= '0;
            acc_lo      <= '0;
            opd         <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            div_zero    <= 1'b0;
            m_f3        <= '0;
        end else begin
            // NOTE: non-blocking assignments; a later load in this block overrides the consume below.
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (dec_ctrl[4] && !dec_illegal) begin
                            acc_hi   <= '0;
                            cnt      <= '0;
                            neg_a    <= ent_neg_a;
                            neg_b    <= ent_neg_b;
                            m_f3     <= bus.funct3;
                            div_zero <= (bus.rs2_data == '0);
                            if (bus.funct3[2]) begin
                                acc_lo <= mag_a;
                                opd    <= mag_b;
                                state  <= S_DIV;
                            end else begin
                                acc_lo <= mag_b;
                                opd    <= mag_a;
                                state  <= S_MUL;
                            end
                        end else begin
                            result_q    <= base_res;
                            ctrl_q      <= dec_ctrl;
                            illegal_q   <= dec_illegal;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) state <= S_DONE;
                end
                S_DIV: begin
                    acc_hi <= div_ge ? rem_diff : rem_shift[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid_q || bus.out_ready) begin
                        result_q    <= m_result;
                        ctrl_q      <= {2'b10, m_f3};
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign bus.in_ready = nreset & (!out_valid_q | bus.out_ready);

    // Output registers: load on accept, clear on consume.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; a later load in this block overrides the consume below.
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                result_q    <= base_res;
                ctrl_q      <= dec_ctrl;
                illegal_q   <= dec_illegal;
                out_valid_q <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq (XLEN=32). Builds with or without
// M_EXT_EN; the reference model follows the same macro.
module tb_alu_exec_seq;
    localparam int XLEN = 32;

    logic clk    = 1'b0;
    logic nreset = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    alu_exec_seq_if #(.XLEN(XLEN)) bus ();

    alu_exec_seq #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: architectural meaning of each instruction with plain arithmetic.
    function automatic void model(
        input  logic [1:0]  op,
        input  logic [2:0]  f3,
        input  logic [6:0]  f7,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [4:0]  ctrl,
        output logic        ctrl_known,
        output logic [31:0] res,
        output logic        ill,
        output int          lat
    );
        logic        mop;
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic        ovf;
        ill = 1'b0; mop = 1'b0; ctrl_known = 1'b1; ctrl = '0; res = '0; lat = 1;
        case (op)
            2'd0: ctrl = 5'b00000;
            2'd1: ctrl = 5'b01000;
            2'd2: begin
                if (f7 == 7'h00) ctrl = {2'b00, f3};
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ctrl = {2'b01, f3};
                else if (f7 == 7'h01) begin
`ifdef M_EXT_EN
                    mop = 1'b1; ctrl = {2'b10, f3};
`else
                    ill = 1'b1; ctrl = 5'b10000;
`endif
                end else begin
                    ill = 1'b1; ctrl_known = 1'b0;
                end
            end
            default: ctrl = {1'b0, (f3 == 3'd5) ? f7[5] : 1'b0, f3};
        endcase
        sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
        ua = {32'd0, a};       ub = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (ill) begin
            res = '0;
        end else if (mop) begin
            lat = XLEN + 1;
            case (f3)
                3'd0: begin p = ua * ub;           res = p[31:0];  end
                3'd1: begin p = sa * sb;           res = p[63:32]; end
                3'd2: begin p = sa * $signed(ub);  res = p[63:32]; end
                3'd3: begin p = ua * ub;           res = p[63:32]; end
                3'd4: res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
                3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: res = (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
                default: res = (b == 0) ? a : a % b;
            endcase
        end else begin
            case (ctrl[3:0])
                4'b0000: res = a + b;
                4'b1000: res = a - b;
                4'b0001: res = a << b[4:0];
                4'b0010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'b0011: res = (a < b) ? 32'd1 : 32'd0;
                4'b0100: res = a ^ b;
                4'b0101: res = a >> b[4:0];
                4'b1101: res = $signed(a) >>> b[4:0];
                4'b0110: res = a | b;
                default: res = a & b;
            endcase
        end
    endfunction

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = op; bus.funct3 = f3; bus.funct7 = f7;
        bus.rs1_data = a; bus.rs2_data = b;
    endtask

    // One request with out_ready=1; returns at the negedge where out_valid is first seen.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  e_ctrl;
        logic        known, e_ill, ir_low;
        logic [31:0] e_res;
        int          e_lat, n;
        model(op, f3, f7, a, b, e_ctrl, known, e_res, e_ill, e_lat);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(op, f3, f7, a, b);
        bus.in_valid = 1'b1;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 0; ir_low = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) break;
            if (bus.in_ready) ir_low = 1'b0;
        end
        check({tag, ".latency"}, 64'(n), 64'(e_lat));
        if (e_lat > 1) check({tag, ".in_ready_busy"}, 64'(ir_low), 64'd1);
        check({tag, ".result"}, 64'(bus.result), 64'(e_res));
        check({tag, ".illegal"}, 64'(bus.illegal), 64'(e_ill));
        if (known) check({tag, ".alu_ctrl"}, 64'(bus.alu_ctrl), 64'(e_ctrl));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [6:0]  rf7;
        logic        seen;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        drive(2'd0, 3'd0, 7'd0, 32'd0, 32'd0);

        // Reset state
        #2 nreset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.in_ready",  64'(bus.in_ready),  64'd0);
        check("rst.result",    64'(bus.result),    64'd0);
        check("rst.alu_ctrl",  64'(bus.alu_ctrl),  64'd0);
        check("rst.illegal",   64'(bus.illegal),   64'd0);
        nreset = 1'b1;
        #1 check("rel.in_ready", 64'(bus.in_ready), 64'd1);

        // Directed base ops
        run_op("xor", 2'b10, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        check("xor.lit", 64'({bus.alu_ctrl, bus.result}), 64'({5'b00100, 32'hFF00_FF00}));
        run_op("add", 2'b10, 3'b000, 7'h00, 32'd7, 32'hFFFF_FFF7);
        check("add.lit", 64'({bus.alu_ctrl, bus.result}), 64'({5'b00000, 32'hFFFF_FFFE}));
        run_op("sra", 2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4);
        check("sra.lit", 64'({bus.alu_ctrl, bus.result}), 64'({5'b01101, 32'hF800_0000}));
        run_op("ill10", 2'b10, 3'b000, 7'h10, 32'h1234_5678, 32'h1);
        check("ill10.lit", 64'({bus.illegal, bus.result}), 64'({1'b1, 32'h0}));

`ifdef M_EXT_EN
        run_op("mulh", 2'b10, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulh.lit", 64'(bus.result), 64'h0);
        run_op("mulhu", 2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu.lit", 64'(bus.result), 64'hFFFF_FFFE);
        run_op("div", 2'b10, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2);
        check("div.lit", 64'(bus.result), 64'hFFFF_FFFD);
        run_op("rem", 2'b10, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2);
        check("rem.lit", 64'(bus.result), 64'hFFFF_FFFF);
        run_op("divu0", 2'b10, 3'b101, 7'h01, 32'h0000_1234, 32'd0);
        check("divu0.lit", 64'(bus.result), 64'hFFFF_FFFF);
        run_op("remu0", 2'b10, 3'b111, 7'h01, 32'd5, 32'd0);
        check("remu0.lit", 64'(bus.result), 64'd5);
        run_op("divovf", 2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf.lit", 64'(bus.result), 64'h8000_0000);
        run_op("removf", 2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
        check("removf.lit", 64'(bus.result), 64'h0);
`else
        run_op("ill01", 2'b10, 3'b100, 7'h01, 32'd9, 32'd3);
        check("ill01.lit", 64'({bus.illegal, bus.alu_ctrl, bus.result}), 64'({1'b1, 5'b10000, 32'h0}));
`endif

        // Backpressure: hold the first ADD, park a second ADD, then consume+accept together.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(2'b10, 3'b000, 7'h00, 32'd100, 32'd23);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 drive(2'b10, 3'b000, 7'h00, 32'd40, 32'd2);
        @(negedge clk);
        check("bp.first_valid", 64'(bus.out_valid), 64'd1);
        check("bp.first_result", 64'(bus.result), 64'd123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp.hold%0d.result", i), 64'(bus.result), 64'd123);
            check($sformatf("bp.hold%0d.valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp.hold%0d.in_ready", i), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 begin bus.in_valid = 1'b0; bus.out_ready = 1'b0; end
        @(negedge clk);
        check("bp.second_valid", 64'(bus.out_valid), 64'd1);
        check("bp.second_result", 64'(bus.result), 64'd42);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp.drained", 64'(bus.out_valid), 64'd0);

        // Reset with an unconsumed result pending
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(2'b01, 3'b000, 7'h00, 32'h50, 32'h10);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("prst.valid_before", 64'(bus.out_valid), 64'd1);
        nreset = 1'b0;
        #1;
        check("prst.out_valid", 64'(bus.out_valid), 64'd0);
        check("prst.result",    64'(bus.result),    64'd0);
        check("prst.alu_ctrl",  64'(bus.alu_ctrl),  64'd0);
        @(negedge clk);
        nreset = 1'b1;
        bus.out_ready = 1'b1;
        run_op("add_after_prst", 2'b00, 3'b000, 7'h00, 32'd5, 32'd6);

`ifdef M_EXT_EN
        // Reset ten cycles into a DIV: the operation is discarded.
        @(negedge clk);
        drive(2'b10, 3'b100, 7'h01, 32'd100, 32'd7);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("drst.out_valid", 64'(bus.out_valid), 64'd0);
        check("drst.in_ready",  64'(bus.in_ready),  64'd0);
        check("drst.result",    64'(bus.result),    64'd0);
        check("drst.alu_ctrl",  64'(bus.alu_ctrl),  64'd0);
        check("drst.illegal",   64'(bus.illegal),   64'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("drst.no_result", 64'(seen), 64'd0);
        check("drst.idle_ready", 64'(bus.in_ready), 64'd1);
`endif
        run_op("add_after_rst", 2'b10, 3'b000, 7'h00, 32'h7FFF_FFFF, 32'd1);

        // Randomised ops against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: rf7 = 7'h00;
                5, 6:          rf7 = 7'h20;
                7, 8:          rf7 = 7'h01;
                default:       rf7 = 7'($urandom);
            endcase
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(0, 40));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 3'($urandom), rf7, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
